// File: rtl/ingress_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ingress_pkg
//  Description : Shared definitions for the ingress VOQ bank. Holds the
//                default metadata layout, the per-cycle request decode
//                record, the destination-field extractor and the helper that
//                locates one VOQ's slice inside the flattened status buses.
//  Revision    : 1.0  initial release
// ============================================================================
package ingress_pkg;

    // Default metadata layout: 32-bit word, destination field starting at bit 28.
    localparam int META_WIDTH_DEF = 32;
    localparam int DEST_LSB_DEF   = 28;

    // Widest metadata word dest_of() can take. Narrower words are zero-extended
    // by the caller.
    localparam int FIELD_MAX_W    = 1024;

    // Per-cycle decode of what the enqueue and grant requests will do.
    typedef struct packed {
        logic enq;   // word is written into its VOQ
        logic drop;  // word is discarded because its VOQ is full
        logic deq;   // grant pops a word
        logic miss;  // grant targets an empty VOQ
    } req_t;

    // Returns the destination field, which is `bits` wide and starts at `lsb`.
    // The field is right-justified in the result.
    function automatic logic [31:0] dest_of(input logic [FIELD_MAX_W-1:0] meta,
                                            input int                     lsb,
                                            input int                     bits);
        return 32'(meta >> lsb) & ((32'd1 << bits) - 32'd1);
    endfunction

    // Returns the low bit of slot `idx` in a flattened bus of `width`-bit slots.
    function automatic int field_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/voq_ram.sv
`default_nettype none
// ============================================================================
//  Module      : voq_ram
//  Description : Simple dual-port storage shared by all VOQs. It has one write
//                port and one read port. The read data is registered, so it
//                appears one cycle after rd_en_i and holds until the next read.
//                The memory array itself is not reset. Only the output
//                register is reset.
//  Ports       : clk, rst_i (async, active-high, output register only)
//                wr_en_i / wr_addr_i / wr_data_i  - write port
//                rd_en_i / rd_addr_i              - read request
//                rd_data_o                        - registered read data
//  Revision    : 1.0  initial release
// ============================================================================
module voq_ram #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/ingress_voq_bank.sv
`default_nettype none
// ============================================================================
//  Module      : ingress_voq_bank
//  Description : Ingress stage with one virtual output queue (VOQ) per egress
//                port. Incoming words are sorted into VOQs by their
//                destination field. A word is dequeued one cycle after a
//                scheduler grant. The block reports occupancy, empty and full
//                flags for each VOQ, keeps a saturating drop counter per VOQ,
//                and pulses a strobe when a grant hits an empty VOQ.
//  Ports       : clk, reset (async, active-high)
//                ingress_in / ingress_in_en      - enqueue side
//                sched_en / sched_sel            - scheduler grant
//                stats_clr                       - clear drop counters
//                ingress_out / ingress_out_valid - registered dequeue output
//                sched_miss                      - grant-to-empty strobe
//                is_empty / is_full / occupancy  - per-VOQ status
//                drop_cnt                        - per-VOQ drop counters
//  Revision    : 1.0  initial release
// ============================================================================
module ingress_voq_bank
    import ingress_pkg::*;
#(
    parameter  int EGRESS_CNT = 4,
    parameter  int VOQ_DEPTH  = 256,
    parameter  int META_WIDTH = META_WIDTH_DEF,
    parameter  int DEST_LSB   = DEST_LSB_DEF,
    parameter  int CNT_WIDTH  = 16,
    localparam int PORT_BITS  = $clog2(EGRESS_CNT),
    localparam int ADDR_BITS  = $clog2(VOQ_DEPTH),
    localparam int OCC_BITS   = ADDR_BITS + 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [META_WIDTH-1:0]            ingress_in,
    input  logic                             ingress_in_en,
    input  logic                             sched_en,
    input  logic [PORT_BITS-1:0]             sched_sel,
    input  logic                             stats_clr,
    output logic [META_WIDTH-1:0]            ingress_out,
    output logic                             ingress_out_valid,
    output logic                             sched_miss,
    output logic [EGRESS_CNT-1:0]            is_empty,
    output logic [EGRESS_CNT-1:0]            is_full,
    output logic [EGRESS_CNT*OCC_BITS-1:0]   occupancy,
    output logic [EGRESS_CNT*CNT_WIDTH-1:0]  drop_cnt
);

    localparam int                 RAM_AW  = PORT_BITS + ADDR_BITS;
    localparam logic [OCC_BITS-1:0] C_FULL = OCC_BITS'(VOQ_DEPTH);
    localparam logic [CNT_WIDTH-1:0] C_SAT = {CNT_WIDTH{1'b1}};

    // Per-VOQ state
    logic [ADDR_BITS-1:0] wr_ptr_q [EGRESS_CNT];
    logic [ADDR_BITS-1:0] wr_ptr_d [EGRESS_CNT];
    logic [ADDR_BITS-1:0] rd_ptr_q [EGRESS_CNT];
    logic [ADDR_BITS-1:0] rd_ptr_d [EGRESS_CNT];
    logic [OCC_BITS-1:0]  occ_q    [EGRESS_CNT];
    logic [OCC_BITS-1:0]  occ_d    [EGRESS_CNT];
    logic [CNT_WIDTH-1:0] drop_q   [EGRESS_CNT];
    logic [CNT_WIDTH-1:0] drop_d   [EGRESS_CNT];

    logic                 valid_q;
    logic                 miss_q;

    logic [EGRESS_CNT-1:0] w_empty;
    logic [EGRESS_CNT-1:0] w_full;
    logic [PORT_BITS-1:0]  w_dest;
    logic                  w_dest_ok;
    logic                  w_full_dest;
    logic                  w_empty_sel;
    logic [ADDR_BITS-1:0]  w_wr_ptr;
    logic [ADDR_BITS-1:0]  w_rd_ptr;
    req_t                  w_req;

    assign w_dest = PORT_BITS'(dest_of(FIELD_MAX_W'(ingress_in), DEST_LSB, PORT_BITS));

    // Flags decode from registered occupancy, so they show the state at the start of the cycle.
    for (genvar gi = 0; gi < EGRESS_CNT; gi++) begin : g_status
        assign w_empty[gi] = (occ_q[gi] == '0);
        assign w_full[gi]  = (occ_q[gi] == C_FULL);
        assign occupancy[field_lo(gi, OCC_BITS)  +: OCC_BITS]  = occ_q[gi];
        assign drop_cnt [field_lo(gi, CNT_WIDTH) +: CNT_WIDTH] = drop_q[gi];
    end

    // Select the addressed VOQ's state. When EGRESS_CNT is not a power of two,
    // a destination outside the bank matches no VOQ and is ignored. A grant to a
    // select outside the bank is treated as a grant to an empty VOQ.
    always_comb begin
        w_dest_ok   = 1'b0;
        w_full_dest = 1'b0;
        w_empty_sel = 1'b1;
        w_wr_ptr    = '0;
        w_rd_ptr    = '0;
        for (int i = 0; i < EGRESS_CNT; i++) begin
            if (w_dest == PORT_BITS'(i)) begin
                w_dest_ok   = 1'b1;
                w_full_dest = w_full[i];
                w_wr_ptr    = wr_ptr_q[i];
            end
            if (sched_sel == PORT_BITS'(i)) begin
                w_empty_sel = w_empty[i];
                w_rd_ptr    = rd_ptr_q[i];
            end
        end
    end

    // The grant checks the empty flag from the start of the cycle. An enqueue
    // into an empty VOQ therefore cannot be popped by a grant in the same cycle.
    always_comb begin
        w_req.enq  = ingress_in_en && w_dest_ok && !w_full_dest;
        w_req.drop = ingress_in_en && w_dest_ok &&  w_full_dest;
        w_req.deq  = sched_en && !w_empty_sel;
        w_req.miss = sched_en &&  w_empty_sel;
    end

    always_comb begin
        for (int i = 0; i < EGRESS_CNT; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i];
            rd_ptr_d[i] = rd_ptr_q[i];
            occ_d[i]    = occ_q[i];
            drop_d[i]   = drop_q[i];

            if (w_req.enq && (w_dest == PORT_BITS'(i))) begin
                wr_ptr_d[i] = wr_ptr_q[i] + 1'b1;
            end
            if (w_req.deq && (sched_sel == PORT_BITS'(i))) begin
                rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
            end

            // A simultaneous push and pop on the same VOQ leaves the count unchanged.
            case ({w_req.enq && (w_dest == PORT_BITS'(i)),
                   w_req.deq && (sched_sel == PORT_BITS'(i))})
                2'b10:   occ_d[i] = occ_q[i] + 1'b1;
                2'b01:   occ_d[i] = occ_q[i] - 1'b1;
                default: occ_d[i] = occ_q[i];
            endcase

            // Clear has priority over a drop in the same cycle.
            if (stats_clr) begin
                drop_d[i] = '0;
            end else if (w_req.drop && (w_dest == PORT_BITS'(i)) && (drop_q[i] != C_SAT)) begin
                drop_d[i] = drop_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < EGRESS_CNT; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                occ_q[i]    <= '0;
                drop_q[i]   <= '0;
            end
            valid_q <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            for (int i = 0; i < EGRESS_CNT; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                occ_q[i]    <= occ_d[i];
                drop_q[i]   <= drop_d[i];
            end
            valid_q <= w_req.deq;
            miss_q  <= w_req.miss;
        end
    end

    // A non-full VOQ that is being read is non-empty, so its read and write
    // pointers differ. A full VOQ drops its write. The two ports therefore never
    // access the same address in one cycle.
    voq_ram #(
        .DEPTH  (EGRESS_CNT * VOQ_DEPTH),
        .ADDR_W (RAM_AW),
        .DATA_W (META_WIDTH)
    ) u_ram (
        .clk       (clk),
        .rst_i     (reset),
        .wr_en_i   (w_req.enq),
        .wr_addr_i ({w_dest, w_wr_ptr}),
        .wr_data_i (ingress_in),
        .rd_en_i   (w_req.deq),
        .rd_addr_i ({sched_sel, w_rd_ptr}),
        .rd_data_o (ingress_out)
    );

    assign ingress_out_valid = valid_q;
    assign sched_miss        = miss_q;
    assign is_empty          = w_empty;
    assign is_full           = w_full;

endmodule
`default_nettype wire

// File: tb/tb_ingress_voq_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ingress_voq_bank
//  Description : Directed self-checking bench for ingress_voq_bank. It uses a
//                small build (4 VOQs of 8 entries, 4-bit drop counters).
//                Expected values are computed by hand.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ingress_voq_bank;

    localparam int EGRESS_CNT = 4;
    localparam int VOQ_DEPTH  = 8;
    localparam int META_WIDTH = 32;
    localparam int DEST_LSB   = 28;
    localparam int CNT_WIDTH  = 4;
    localparam int PORT_BITS  = 2;
    localparam int OCC_BITS   = 4;

    logic                            clk;
    logic                            reset;
    logic [META_WIDTH-1:0]           ingress_in;
    logic                            ingress_in_en;
    logic                            sched_en;
    logic [PORT_BITS-1:0]            sched_sel;
    logic                            stats_clr;
    logic [META_WIDTH-1:0]           ingress_out;
    logic                            ingress_out_valid;
    logic                            sched_miss;
    logic [EGRESS_CNT-1:0]           is_empty;
    logic [EGRESS_CNT-1:0]           is_full;
    logic [EGRESS_CNT*OCC_BITS-1:0]  occupancy;
    logic [EGRESS_CNT*CNT_WIDTH-1:0] drop_cnt;

    int checks = 0;
    int passed = 0;

    ingress_voq_bank #(
        .EGRESS_CNT (EGRESS_CNT),
        .VOQ_DEPTH  (VOQ_DEPTH),
        .META_WIDTH (META_WIDTH),
        .DEST_LSB   (DEST_LSB),
        .CNT_WIDTH  (CNT_WIDTH)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .ingress_in        (ingress_in),
        .ingress_in_en     (ingress_in_en),
        .sched_en          (sched_en),
        .sched_sel         (sched_sel),
        .stats_clr         (stats_clr),
        .ingress_out       (ingress_out),
        .ingress_out_valid (ingress_out_valid),
        .sched_miss        (sched_miss),
        .is_empty          (is_empty),
        .is_full           (is_full),
        .occupancy         (occupancy),
        .drop_cnt          (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [OCC_BITS-1:0] occ_of(input int i);
        return occupancy[i*OCC_BITS +: OCC_BITS];
    endfunction

    function automatic logic [CNT_WIDTH-1:0] drop_of(input int i);
        return drop_cnt[i*CNT_WIDTH +: CNT_WIDTH];
    endfunction

    // Advance one cycle. Outputs are sampled, and inputs changed, 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [31:0] d);
        ingress_in    = d;
        ingress_in_en = 1'b1;
        tick();
        ingress_in_en = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (is_empty !== 4'hF) $display("FAIL reset_empty: got %h want f", is_empty); else passed++;
        checks++; if (is_full !== 4'h0) $display("FAIL reset_full: got %h want 0", is_full); else passed++;
        checks++; if (occupancy !== '0) $display("FAIL reset_occ: got %h want 0", occupancy); else passed++;
        checks++; if (drop_cnt !== '0) $display("FAIL reset_drop: got %h want 0", drop_cnt); else passed++;
        checks++; if ({ingress_out_valid, sched_miss} !== 2'b00) $display("FAIL reset_strobes: got %b want 00", {ingress_out_valid, sched_miss}); else passed++;
        checks++; if (ingress_out !== 32'h0) $display("FAIL reset_out: got %h want 0", ingress_out); else passed++;
    endtask

    // Push three words into VOQ 2 and pop them in order.
    task automatic test_basic(input string tag);
        for (int k = 1; k <= 3; k++) enq(32'h2000_0000 + k);
        checks++; if (occ_of(2) !== 4'd3) $display("FAIL %s_occ3: got %0d want 3", tag, occ_of(2)); else passed++;
        sched_en = 1'b1; sched_sel = 2'd2;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++; if (ingress_out_valid !== 1'b1 || ingress_out !== 32'h2000_0000 + k)
                $display("FAIL %s_deq%0d: got %b/%h want 1/%h", tag, k, ingress_out_valid, ingress_out, 32'h2000_0000 + k); else passed++;
            checks++; if (occ_of(2) !== 4'(3 - k)) $display("FAIL %s_occ_dec%0d: got %0d want %0d", tag, k, occ_of(2), 3 - k); else passed++;
        end
        sched_en = 1'b0;
        tick();
        checks++; if (ingress_out_valid !== 1'b0 || ingress_out !== 32'h2000_0003)
            $display("FAIL %s_hold: got %b/%h want 0/20000003", tag, ingress_out_valid, ingress_out); else passed++;
        checks++; if (is_empty[2] !== 1'b1) $display("FAIL %s_empty2: got %b want 1", tag, is_empty[2]); else passed++;
    endtask

    // Fill VOQ 1, overflow it by two, drain it, then refill it past the pointer wrap.
    task automatic test_full_wrap();
        for (int k = 0; k < VOQ_DEPTH; k++) enq(32'h1000_0000 + k);
        checks++; if (is_full[1] !== 1'b1) $display("FAIL full_flag: got %b want 1", is_full[1]); else passed++;
        enq(32'h1000_00AA); enq(32'h1000_00BB);
        checks++; if (drop_of(1) !== 4'd2) $display("FAIL full_drop: got %0d want 2", drop_of(1)); else passed++;
        checks++; if (occ_of(1) !== 4'd8) $display("FAIL full_occ: got %0d want 8", occ_of(1)); else passed++;
        sched_en = 1'b1; sched_sel = 2'd1;
        for (int k = 0; k < VOQ_DEPTH; k++) begin
            tick();
            checks++; if (ingress_out_valid !== 1'b1 || ingress_out !== 32'h1000_0000 + k)
                $display("FAIL drain%0d: got %b/%h want 1/%h", k, ingress_out_valid, ingress_out, 32'h1000_0000 + k); else passed++;
        end
        sched_en = 1'b0;
        tick();
        checks++; if (is_empty[1] !== 1'b1) $display("FAIL drain_empty: got %b want 1", is_empty[1]); else passed++;
        for (int k = 0; k < 3; k++) enq(32'h1000_0100 + k);
        sched_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (ingress_out !== 32'h1000_0100 + k) $display("FAIL wrap%0d: got %h want %h", k, ingress_out, 32'h1000_0100 + k); else passed++;
        end
        sched_en = 1'b0;
        tick();
    endtask

    task automatic test_miss();
        sched_en = 1'b1; sched_sel = 2'd3;
        tick();
        sched_en = 1'b0;
        checks++; if ({sched_miss, ingress_out_valid} !== 2'b10) $display("FAIL miss3: got %b want 10", {sched_miss, ingress_out_valid}); else passed++;
        tick();
        checks++; if (sched_miss !== 1'b0) $display("FAIL miss_pulse: got %b want 0", sched_miss); else passed++;
        checks++; if (occ_of(3) !== 4'd0) $display("FAIL miss_occ3: got %0d want 0", occ_of(3)); else passed++;
        // An enqueue and a grant hit the empty VOQ 0 in the same cycle: the grant misses and the enqueue lands.
        ingress_in = 32'h0000_0055; ingress_in_en = 1'b1; sched_en = 1'b1; sched_sel = 2'd0;
        tick();
        ingress_in_en = 1'b0; sched_en = 1'b0;
        checks++; if ({sched_miss, ingress_out_valid} !== 2'b10) $display("FAIL miss_ft: got %b want 10", {sched_miss, ingress_out_valid}); else passed++;
        checks++; if (occ_of(0) !== 4'd1) $display("FAIL miss_ft_occ: got %0d want 1", occ_of(0)); else passed++;
        sched_en = 1'b1;
        tick();
        sched_en = 1'b0;
        checks++; if (ingress_out_valid !== 1'b1 || ingress_out !== 32'h55) $display("FAIL miss_pop: got %b/%h want 1/55", ingress_out_valid, ingress_out); else passed++;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 5; k++) enq(32'h0000_0100 + k);
        sched_en = 1'b1; sched_sel = 2'd0; ingress_in_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            ingress_in = 32'h0000_0200 + k;
            tick();
            checks++; if (ingress_out !== ((k < 5) ? 32'h100 + k : 32'h200 + k - 5))
                $display("FAIL b2b%0d: got %h want %h", k, ingress_out, (k < 5) ? 32'h100 + k : 32'h200 + k - 5); else passed++;
            checks++; if (occ_of(0) !== 4'd5) $display("FAIL b2b_occ%0d: got %0d want 5", k, occ_of(0)); else passed++;
        end
        ingress_in_en = 1'b0;
        for (int k = 5; k < 10; k++) begin
            tick();
            checks++; if (ingress_out !== 32'h200 + k) $display("FAIL b2b_tail%0d: got %h want %h", k, ingress_out, 32'h200 + k); else passed++;
        end
        sched_en = 1'b0;
        tick();
        checks++; if (is_empty[0] !== 1'b1) $display("FAIL b2b_empty: got %b want 1", is_empty[0]); else passed++;
    endtask

    task automatic test_saturate();
        for (int k = 0; k < VOQ_DEPTH; k++) enq(32'h0000_0300 + k);
        ingress_in = 32'h0000_0999; ingress_in_en = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 10) begin
                checks++; if (drop_of(0) !== 4'd10) $display("FAIL sat_mid: got %0d want 10", drop_of(0)); else passed++;
            end
        end
        checks++; if (drop_of(0) !== 4'd15) $display("FAIL sat_hold: got %0d want 15", drop_of(0)); else passed++;
        // Clear in the same cycle as another drop; the ingress enable is still high.
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0; ingress_in_en = 1'b0;
        checks++; if (drop_of(0) !== 4'd0) $display("FAIL clr0: got %0d want 0", drop_of(0)); else passed++;
        checks++; if (drop_of(1) !== 4'd0) $display("FAIL clr1: got %0d want 0", drop_of(1)); else passed++;
        checks++; if (occ_of(0) !== 4'd8) $display("FAIL clr_occ: got %0d want 8", occ_of(0)); else passed++;
    endtask

    task automatic test_async_reset();
        sched_en = 1'b1; sched_sel = 2'd0;
        tick();
        checks++; if (ingress_out_valid !== 1'b1 || ingress_out !== 32'h300) $display("FAIL pre_rst: got %b/%h want 1/300", ingress_out_valid, ingress_out); else passed++;
        #3 reset = 1'b1;
        #1;
        checks++; if (is_empty !== 4'hF) $display("FAIL arst_empty: got %h want f", is_empty); else passed++;
        checks++; if (occupancy !== '0) $display("FAIL arst_occ: got %h want 0", occupancy); else passed++;
        checks++; if (ingress_out_valid !== 1'b0) $display("FAIL arst_valid: got %b want 0", ingress_out_valid); else passed++;
        sched_en = 1'b0;
        tick();
        #2 reset = 1'b0;
        tick();
        test_basic("post");
    endtask

    initial begin
        reset = 1'b1; ingress_in = '0; ingress_in_en = 1'b0;
        sched_en = 1'b0; sched_sel = '0; stats_clr = 1'b0;
        tick(); tick();
        test_reset();
        reset = 1'b0;
        test_basic("basic");
        test_full_wrap();
        test_miss();
        test_back_to_back();
        test_saturate();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ingress_voq_bank.md
Name: ingress_voq_bank

Overview:
Parametrised next-generation ingress stage. It sorts incoming fixed-length metadata words into one virtual output queue (VOQ) per egress port, keyed on a destination field. Words are dequeued on scheduler grants toward the crossbar. It adds features the previous generation lacks:
- arbitrary egress count and VOQ depth;
- a registered output with a valid strobe;
- per-VOQ occupancy reporting;
- saturating per-VOQ drop counters and a grant-miss strobe.

Parameters:
EGRESS_CNT, 4, number of egress ports / VOQs (>=2)
VOQ_DEPTH, 256, entries per VOQ; power of two, >=2
META_WIDTH, 32, metadata word width
DEST_LSB, 28, LSB of destination field inside ingress_in; field width is PORT_BITS
CNT_WIDTH, 16, drop-counter width
Derived localparams: PORT_BITS=$clog2(EGRESS_CNT), ADDR_BITS=$clog2(VOQ_DEPTH), OCC_BITS=ADDR_BITS+1.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
ingress_in  in  META_WIDTH  metadata word; dest = ingress_in[DEST_LSB +: PORT_BITS]
ingress_in_en  in  1  enqueue request, one word per cycle
sched_en  in  1  scheduler grant (dequeue request)
sched_sel  in  PORT_BITS  VOQ selected by grant
stats_clr  in  1  synchronous clear of drop counters
ingress_out  out  META_WIDTH  dequeued word, to crossbar
ingress_out_valid  out  1  ingress_out carries a fresh word this cycle
sched_miss  out  1  pulse: previous-cycle grant hit an empty VOQ
is_empty  out  EGRESS_CNT  per-VOQ empty flag, to scheduler
is_full  out  EGRESS_CNT  per-VOQ full flag
occupancy  out  EGRESS_CNT*OCC_BITS  per-VOQ count; VOQ i at [i*OCC_BITS +: OCC_BITS]
drop_cnt  out  EGRESS_CNT*CNT_WIDTH  per-VOQ dropped-enqueue count; VOQ i at [i*CNT_WIDTH +: CNT_WIDTH]

Behaviour:
Reset values (asynchronous):
- all rd_ptr, wr_ptr, occupancy = 0; is_empty = all 1; is_full = all 0.
- ingress_out = 0; ingress_out_valid = 0; sched_miss = 0; drop_cnt = 0.
- RAM contents are not reset.

Flags:
- is_empty[i] = (occ[i]==0); is_full[i] = (occ[i]==VOQ_DEPTH).
- Flags decode combinationally from registered occ, so they reflect start-of-cycle state.

Enqueue:
- Accepted iff ingress_in_en && !is_full[dest].
- Accepted word is written to RAM address {dest, wr_ptr[dest]}; wr_ptr[dest] increments mod VOQ_DEPTH.
- If ingress_in_en && is_full[dest], the word is dropped and drop_cnt[dest] increments, saturating at 2^CNT_WIDTH-1.

Dequeue:
- Accepted iff sched_en && !is_empty[sched_sel].
- RAM read address is {sched_sel, rd_ptr[sched_sel]}; rd_ptr increments mod VOQ_DEPTH.
- Latency is exactly 1 cycle: ingress_out and ingress_out_valid=1 are registered on the next edge.
- When no word is output, ingress_out holds its last value and valid=0.
- sched_en && is_empty[sched_sel] → no pointer change; sched_miss=1 for one cycle, aligned with where valid would have been.

Simultaneous events:
- Enqueue and dequeue to different VOQs: independent.
- Same VOQ, neither empty nor full: both happen, occ unchanged.
- Empty VOQ + enqueue + grant same cycle: grant misses (sched_miss); enqueue succeeds. No fall-through.
- Full VOQ + enqueue + grant same cycle: grant succeeds; enqueue dropped (drop counted).
- Read and write never target the same RAM address in one cycle: a non-empty, non-full VOQ has rd_ptr!=wr_ptr, and the full case drops the write.

Counters:
- stats_clr zeroes all drop_cnt and wins over a same-cycle drop (result 0).
- occupancy is unaffected by stats_clr.

Reset mid-operation: all queues become empty immediately; any in-flight read output is discarded (valid=0).

Decomposition:
- Package ingress_pkg holds:
  - meta field offsets (DEST_LSB default, field widths);
  - helper function dest_of(meta) returning the destination field;
  - a function flattening/indexing the occupancy and drop_cnt buses.
- Sub-module voq_ram: simple dual-port RAM, EGRESS_CNT*VOQ_DEPTH × META_WIDTH, one write port, one read port with a registered 1-cycle read.
- Pointer, occupancy and counter logic stays in ingress_voq_bank.

Test Plan:
1. Reset, then enqueue 3 words with dest=2 (values 0x2000_0001..3), then grant sel=2 three cycles → ingress_out 0x2000_0001,2,3 each one cycle after its grant, valid=1; occ[2] goes 3→0; is_empty[2]=1 at end.
2. Fill VOQ 1 with VOQ_DEPTH words, then 2 more enqueues → is_full[1]=1, drop_cnt[1]=2, occ[1]=VOQ_DEPTH; drain all → data returned in order, pointers wrap correctly, is_empty[1]=1.
3. Grant sel=3 on empty VOQ 3 → sched_miss=1 next cycle, valid=0, no pointer change. Then enqueue + grant to empty VOQ 0 in the same cycle → sched_miss=1, occ[0]=1.
4. VOQ 0 holding 5 words, simultaneous enqueue(dest 0) + grant(sel 0) for 10 cycles → occ[0] stays 5, FIFO order preserved across interleave.
5. Force drop_cnt[0] to saturate (CNT_WIDTH=4 build: 20 drops) → holds 15. Then stats_clr asserted with a concurrent drop → drop_cnt[0]=0.
6. Assert reset asynchronously mid-traffic between edges → is_empty all 1, valid=0, occ all 0 immediately; post-reset traffic behaves as in scenario 1.
